// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one line-wide physical memory port between the
// I-cache (fills) and D-cache (fills and writebacks); one transaction at a time.
module cacheline_arbiter #(
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_read,
   input  logic [ADDR_WIDTH-1:0] icache_address,
   output logic [LINE_WIDTH-1:0] icache_rdata,
   output logic                  icache_resp,
   input  logic                  dcache_read,
   input  logic                  dcache_write,
   input  logic [ADDR_WIDTH-1:0] dcache_address,
   input  logic [LINE_WIDTH-1:0] dcache_wdata,
   output logic [LINE_WIDTH-1:0] dcache_rdata,
   output logic                  dcache_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} req_t;

   state_t                state;
   req_t                  last_grant;
   req_t                  winner;
   req_t                  next_winner;
   logic                  op_write;
   logic                  icache_req;
   logic                  dcache_req;
   logic [LINE_WIDTH-1:0] line;

   assign icache_req   = icache_read;
   assign dcache_req   = dcache_read | dcache_write;
   assign icache_rdata = line;
   assign dcache_rdata = line;

   // NOTE: next_winner gets a value on every path through the block, so no latch is inferred.
   always_comb begin
      next_winner = DCACHE;
      if (icache_req && dcache_req) begin
         next_winner = (last_grant == ICACHE) ? DCACHE : ICACHE;
      end else if (icache_req) begin
         next_winner = ICACHE;
      end
   end

   // NOTE: all state updates are non-blocking so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last_grant   <= ICACHE;
         winner       <= ICACHE;
         op_write     <= 1'b0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         // NOTE: the wide line/wdata registers are cleared too, so outputs are defined right after reset.
         pmem_wdata   <= '0;
         line         <= '0;
         icache_resp  <= 1'b0;
         dcache_resp  <= 1'b0;
      end else begin
         icache_resp <= 1'b0;
         dcache_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (icache_req || dcache_req) begin
                  winner <= next_winner;
                  state  <= BUSY;
                  if (next_winner == DCACHE) begin
                     // A writeback wins over a simultaneous (illegal) fill request.
                     op_write     <= dcache_write;
                     pmem_read    <= ~dcache_write;
                     pmem_write   <= dcache_write;
                     pmem_address <= dcache_address;
                     pmem_wdata   <= dcache_wdata;
                  end else begin
                     op_write     <= 1'b0;
                     pmem_read    <= 1'b1;
                     pmem_write   <= 1'b0;
                     pmem_address <= icache_address;
                  end
               end
            end
            BUSY: begin
               if (pmem_resp) begin
                  if (!op_write) begin
                     line <= pmem_rdata;
                  end
                  pmem_read   <= 1'b0;
                  pmem_write  <= 1'b0;
                  icache_resp <= (winner == ICACHE);
                  dcache_resp <= (winner == DCACHE);
                  state       <= RESP;
               end
            end
            RESP: begin
               last_grant <= winner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
